// File: rtl/lfsr_sym_checker_pkg.sv
// rtl/lfsr_sym_checker_pkg.sv - shared LFSR constants and checker state encodings
package lfsr_sym_checker_pkg;

  localparam int LFSR_LEN = 7;
  localparam logic [LFSR_LEN-1:0] LFSR_SEED = 7'h01;
  // x^7 + x^6 + 1, primitive: period 127
  localparam logic [LFSR_LEN-1:0] LFSR_TAPS = 7'h60;
  localparam int SYM_W = 4;

  typedef enum logic [1:0] {
    CHK_SEARCH = 2'd0,
    CHK_VERIFY = 2'd1,
    CHK_LOCKED = 2'd2
  } chk_state_e;

endpackage

// File: rtl/lfsr_gen_max.sv
// rtl/lfsr_gen_max.sv - maximal-length Fibonacci LFSR, one 4-bit symbol per strobe
module lfsr_gen_max
  import lfsr_sym_checker_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             clk_en,
  output logic [SYM_W-1:0] sym_out,
  output logic             cycle_out_periodic
);

  logic [LFSR_LEN-1:0] state_q, state_d;

  always_comb begin
    state_d = state_q;
    if (clk_en) begin
      state_d = {state_q[LFSR_LEN-2:0], ^(state_q & LFSR_TAPS)};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= LFSR_SEED;
    end else begin
      state_q <= state_d;
    end
  end

  assign sym_out            = state_q[SYM_W-1:0];
  // Marks the strobe on which the sequence sits at its seed, once per period
  assign cycle_out_periodic = clk_en & (state_q == LFSR_SEED);

endmodule

// File: rtl/lfsr_sym_checker.sv
// rtl/lfsr_sym_checker.sv - aligns an LFSR replica to decided symbols and counts errors
module lfsr_sym_checker
  import lfsr_sym_checker_pkg::*;
#(
  parameter int LOCK_COUNT    = 32,
  parameter int UNLOCK_WINDOW = 64,
  parameter int UNLOCK_THRESH = 8,
  parameter int CNT_W         = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clk_en,
  input  logic [SYM_W-1:0] sym_in,
  output logic             locked,
  output logic             sym_err,
  output logic             meas_valid,
  output logic [CNT_W-1:0] bit_err_total,
  output logic [CNT_W-1:0] sym_err_total,
  output logic [CNT_W-1:0] sym_total,
  output logic [15:0]      lock_loss_cnt
);

  localparam int MC_W = $clog2(LOCK_COUNT + 1);
  localparam int WC_W = $clog2(UNLOCK_WINDOW);
  localparam int WE_W = $clog2(UNLOCK_THRESH + 1);
  localparam logic [MC_W-1:0] LOCK_LAST   = MC_W'(LOCK_COUNT - 1);
  localparam logic [WC_W-1:0] WIN_LAST    = WC_W'(UNLOCK_WINDOW - 1);
  localparam logic [WE_W-1:0] THRESH_LAST = WE_W'(UNLOCK_THRESH - 1);

  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                               input logic [CNT_W-1:0] b);
    logic [CNT_W:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[CNT_W] ? {CNT_W{1'b1}} : s[CNT_W-1:0];
  endfunction

  function automatic logic [2:0] popcount4(input logic [SYM_W-1:0] v);
    logic [2:0] c;
    c = '0;
    for (int i = 0; i < SYM_W; i++) c = c + {2'b00, v[i]};
    return c;
  endfunction

  chk_state_e       state_q, state_d;
  logic [MC_W-1:0]  match_cnt_q, match_cnt_d;
  logic [WC_W-1:0]  win_cnt_q, win_cnt_d;
  logic [WE_W-1:0]  win_err_q, win_err_d;
  logic [CNT_W-1:0] live_sym_q, live_sym_d, live_err_q, live_err_d, live_bit_q, live_bit_d;
  logic [CNT_W-1:0] sym_tot_q, sym_tot_d, err_tot_q, err_tot_d, bit_tot_q, bit_tot_d;
  logic [CNT_W-1:0] base_sym, base_err, base_bit;
  logic [15:0]      lock_loss_q, lock_loss_d;
  logic             sym_err_q, sym_err_d, meas_valid_q, meas_valid_d;

  logic [SYM_W-1:0] ref_sym, diff;
  logic             ref_periodic, mismatch, slip;

  assign diff     = sym_in ^ ref_sym;
  assign mismatch = (diff != '0);
  // Holding the replica for one strobe walks its phase back by one symbol
  assign slip     = clk_en & mismatch & (state_q != CHK_LOCKED);

  lfsr_gen_max u_ref (
    .clk                (clk),
    .reset              (reset),
    .clk_en             (clk_en & ~slip),
    .sym_out            (ref_sym),
    .cycle_out_periodic (ref_periodic)
  );

  always_comb begin
    state_d      = state_q;
    match_cnt_d  = match_cnt_q;
    win_cnt_d    = win_cnt_q;
    win_err_d    = win_err_q;
    live_sym_d   = live_sym_q;
    live_err_d   = live_err_q;
    live_bit_d   = live_bit_q;
    sym_tot_d    = sym_tot_q;
    err_tot_d    = err_tot_q;
    bit_tot_d    = bit_tot_q;
    lock_loss_d  = lock_loss_q;
    sym_err_d    = 1'b0;
    meas_valid_d = 1'b0;
    base_sym     = live_sym_q;
    base_err     = live_err_q;
    base_bit     = live_bit_q;
    if (clk_en) begin
      case (state_q)
        CHK_SEARCH: begin
          if (!mismatch) begin
            state_d     = CHK_VERIFY;
            match_cnt_d = MC_W'(1);
          end
        end
        CHK_VERIFY: begin
          if (mismatch) begin
            state_d     = CHK_SEARCH;
            match_cnt_d = '0;
          end else if (match_cnt_q == LOCK_LAST) begin
            state_d     = CHK_LOCKED;
            match_cnt_d = '0;
            win_cnt_d   = '0;
            win_err_d   = '0;
            live_sym_d  = '0;
            live_err_d  = '0;
            live_bit_d  = '0;
          end else begin
            match_cnt_d = match_cnt_q + 1'b1;
          end
        end
        CHK_LOCKED: begin
          // Snapshot closes the old period; this strobe opens the new one
          if (ref_periodic) begin
            sym_tot_d    = live_sym_q;
            err_tot_d    = live_err_q;
            bit_tot_d    = live_bit_q;
            meas_valid_d = 1'b1;
            base_sym     = '0;
            base_err     = '0;
            base_bit     = '0;
          end
          live_sym_d = sat_add(base_sym, CNT_W'(1));
          live_err_d = base_err;
          live_bit_d = base_bit;
          if (mismatch) begin
            sym_err_d  = 1'b1;
            live_err_d = sat_add(base_err, CNT_W'(1));
            live_bit_d = sat_add(base_bit, CNT_W'(popcount4(diff)));
            if (win_err_q == THRESH_LAST) begin
              state_d     = CHK_SEARCH;
              lock_loss_d = (lock_loss_q == 16'hFFFF) ? lock_loss_q : lock_loss_q + 16'd1;
            end
          end
          if (win_cnt_q == WIN_LAST) begin
            win_cnt_d = '0;
            win_err_d = '0;
          end else begin
            win_cnt_d = win_cnt_q + 1'b1;
            win_err_d = win_err_q + {{(WE_W-1){1'b0}}, mismatch};
          end
        end
        default: state_d = CHK_SEARCH;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= CHK_SEARCH;
      match_cnt_q  <= '0;
      win_cnt_q    <= '0;
      win_err_q    <= '0;
      live_sym_q   <= '0;
      live_err_q   <= '0;
      live_bit_q   <= '0;
      sym_tot_q    <= '0;
      err_tot_q    <= '0;
      bit_tot_q    <= '0;
      lock_loss_q  <= '0;
      sym_err_q    <= 1'b0;
      meas_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      match_cnt_q  <= match_cnt_d;
      win_cnt_q    <= win_cnt_d;
      win_err_q    <= win_err_d;
      live_sym_q   <= live_sym_d;
      live_err_q   <= live_err_d;
      live_bit_q   <= live_bit_d;
      sym_tot_q    <= sym_tot_d;
      err_tot_q    <= err_tot_d;
      bit_tot_q    <= bit_tot_d;
      lock_loss_q  <= lock_loss_d;
      sym_err_q    <= sym_err_d;
      meas_valid_q <= meas_valid_d;
    end
  end

  assign locked        = (state_q == CHK_LOCKED);
  assign sym_err       = sym_err_q;
  assign meas_valid    = meas_valid_q;
  assign bit_err_total = bit_tot_q;
  assign sym_err_total = err_tot_q;
  assign sym_total     = sym_tot_q;
  assign lock_loss_cnt = lock_loss_q;

endmodule

// File: tb/tb_lfsr_sym_checker.sv
// tb/tb_lfsr_sym_checker.sv - self-checking bench for lfsr_sym_checker
module tb_lfsr_sym_checker;

  localparam int CNT_W  = 32;
  localparam int PERIOD = 127;
  localparam int WIN    = 64;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        src_reset = 1'b1;
  logic        clk_en = 1'b0;
  logic        src_en = 1'b0;
  logic [3:0]  corrupt = 4'h0;
  logic [3:0]  src_sym, sym_in;
  logic        src_periodic;
  logic        locked, sym_err, meas_valid;
  logic [CNT_W-1:0] bit_err_total, sym_err_total, sym_total;
  logic [15:0] lock_loss_cnt;

  typedef struct {
    int bits;
    int errs;
    int syms;
  } snap_t;

  snap_t snap_q[$];
  snap_t mon_e;
  int    total = 0;
  int    bad = 0;
  int    phase = 0;
  int    m_bits = 0, m_errs = 0, m_syms = 0, win_pos = 0;
  bit    model_locked = 1'b0;

  always #5 clk = ~clk;

  assign sym_in = src_sym ^ corrupt;

  lfsr_gen_max u_src (
    .clk                (clk),
    .reset              (src_reset),
    .clk_en             (src_en),
    .sym_out            (src_sym),
    .cycle_out_periodic (src_periodic)
  );

  lfsr_sym_checker #(
    .LOCK_COUNT    (32),
    .UNLOCK_WINDOW (64),
    .UNLOCK_THRESH (8),
    .CNT_W         (CNT_W)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .clk_en        (clk_en),
    .sym_in        (sym_in),
    .locked        (locked),
    .sym_err       (sym_err),
    .meas_valid    (meas_valid),
    .bit_err_total (bit_err_total),
    .sym_err_total (sym_err_total),
    .sym_total     (sym_total),
    .lock_loss_cnt (lock_loss_cnt)
  );

  // Scoreboard consumer: every meas_valid pops the expected snapshot
  always @(negedge clk) begin
    if (!reset && meas_valid) begin
      if (snap_q.size() == 0) begin
        total++; bad++;
        $display("FAIL snap_unexpected: meas_valid=1 with no snapshot expected");
      end else begin
        mon_e = snap_q.pop_front();
        total++;
        if (sym_total !== CNT_W'(mon_e.syms)) begin
          bad++; $display("FAIL snap_sym_total: got %0d want %0d", sym_total, mon_e.syms);
        end
        total++;
        if (sym_err_total !== CNT_W'(mon_e.errs)) begin
          bad++; $display("FAIL snap_sym_err_total: got %0d want %0d", sym_err_total, mon_e.errs);
        end
        total++;
        if (bit_err_total !== CNT_W'(mon_e.bits)) begin
          bad++; $display("FAIL snap_bit_err_total: got %0d want %0d", bit_err_total, mon_e.bits);
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic strobe(input logic [3:0] mask);
    bit exp_snap, exp_err;
    corrupt  = mask;
    clk_en   = 1'b1;
    src_en   = 1'b1;
    exp_snap = model_locked && (phase == 0);
    exp_err  = model_locked && (mask != 4'h0);
    if (exp_snap) begin
      snap_q.push_back('{bits: m_bits, errs: m_errs, syms: m_syms});
      m_bits = 0; m_errs = 0; m_syms = 0;
    end
    if (model_locked) begin
      m_syms++;
      if (mask != 4'h0) begin
        m_errs++;
        m_bits += $countones(mask);
      end
      win_pos = (win_pos + 1) % WIN;
    end
    #1;
    total++;
    if (src_periodic !== (phase == 0)) begin
      bad++; $display("FAIL src_period: got %b want %b at phase %0d", src_periodic, (phase == 0), phase);
    end
    @(negedge clk);
    corrupt = 4'h0;
    clk_en  = 1'b0;
    src_en  = 1'b0;
    phase   = (phase + 1) % PERIOD;
    total++;
    if (meas_valid !== exp_snap) begin
      bad++; $display("FAIL meas_valid_pulse: got %b want %b", meas_valid, exp_snap);
    end
    total++;
    if (sym_err !== exp_err) begin
      bad++; $display("FAIL sym_err_pulse: got %b want %b", sym_err, exp_err);
    end
  endtask

  task automatic model_clear();
    snap_q.delete();
    phase = 0; model_locked = 1'b0; win_pos = 0;
    m_bits = 0; m_errs = 0; m_syms = 0;
  endtask

  task automatic model_lock_entry();
    model_locked = 1'b1; win_pos = 0;
    m_bits = 0; m_errs = 0; m_syms = 0;
  endtask

  task automatic test_reset();
    reset = 1'b1; src_reset = 1'b1;
    repeat (3) @(negedge clk);
    total++;
    if ({locked, sym_err, meas_valid} !== 3'b000) begin
      bad++; $display("FAIL reset_flags: got %b want 000", {locked, sym_err, meas_valid});
    end
    total++;
    if ((bit_err_total | sym_err_total | sym_total) !== '0 || lock_loss_cnt !== 16'd0) begin
      bad++; $display("FAIL reset_counters: got bit=%0d err=%0d sym=%0d loss=%0d want all 0",
                      bit_err_total, sym_err_total, sym_total, lock_loss_cnt);
    end
    reset = 1'b0; src_reset = 1'b0;
    model_clear();
    @(negedge clk);
    total++;
    if (locked !== 1'b0) begin
      bad++; $display("FAIL idle_after_reset: locked got %b want 0", locked);
    end
  endtask

  task automatic test_aligned();
    for (int k = 1; k <= 32; k++) begin
      strobe(4'h0);
      if (k == 31) begin
        total++;
        if (locked !== 1'b0) begin
          bad++; $display("FAIL aligned_early_lock: locked got %b want 0 after 31", locked);
        end
      end
    end
    total++;
    if (locked !== 1'b1) begin
      bad++; $display("FAIL aligned_lock_32: locked got %b want 1", locked);
    end
    model_lock_entry();
    repeat (300) strobe(4'h0);
  endtask

  task automatic test_offset();
    int n;
    @(negedge clk);
    reset = 1'b1; src_reset = 1'b1;
    @(negedge clk);
    reset = 1'b0; src_reset = 1'b0;
    model_clear();
    src_en = 1'b1;
    repeat (5) @(negedge clk);
    src_en = 1'b0;
    phase = 5;
    n = 0;
    while (!locked && n < 3000) begin
      strobe(4'h0);
      n++;
    end
    total++;
    if (locked !== 1'b1) begin
      bad++; $display("FAIL offset_lock: locked got %b want 1 within 3000 strobes", locked);
    end
    model_lock_entry();
    repeat (200) strobe(4'h0);
    total++;
    if (locked !== 1'b1 || lock_loss_cnt !== 16'd0) begin
      bad++; $display("FAIL offset_hold: locked=%b loss=%0d want locked=1 loss=0", locked, lock_loss_cnt);
    end
  endtask

  task automatic test_single_fault();
    while (phase != 1) strobe(4'h0);
    strobe(4'b0101);
    repeat (PERIOD + 2) strobe(4'h0);
    total++;
    if (locked !== 1'b1) begin
      bad++; $display("FAIL single_fault_lock: locked got %b want 1", locked);
    end
  endtask

  task automatic test_burst();
    while (win_pos != 0) strobe(4'h0);
    for (int i = 0; i < 8; i++) begin
      strobe(4'hF);
      if (i == 6) begin
        total++;
        if (locked !== 1'b1) begin
          bad++; $display("FAIL burst_seventh: locked got %b want 1", locked);
        end
      end
    end
    model_locked = 1'b0;
    total++;
    if (locked !== 1'b0) begin
      bad++; $display("FAIL burst_unlock: locked got %b want 0", locked);
    end
    total++;
    if (lock_loss_cnt !== 16'd1) begin
      bad++; $display("FAIL burst_loss_cnt: got %0d want 1", lock_loss_cnt);
    end
    for (int k = 1; k <= 32; k++) begin
      strobe(4'h0);
      if (k == 31) begin
        total++;
        if (locked !== 1'b0) begin
          bad++; $display("FAIL relock_early: locked got %b want 0", locked);
        end
      end
    end
    total++;
    if (locked !== 1'b1) begin
      bad++; $display("FAIL relock: locked got %b want 1", locked);
    end
    model_lock_entry();
    repeat (140) strobe(4'h0);
  endtask

  task automatic test_stall();
    corrupt = 4'hF;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      total++;
      if ({locked, sym_err, meas_valid} !== 3'b100) begin
        bad++; $display("FAIL stall_frozen: got locked/sym_err/meas_valid=%b want 100 at cycle %0d",
                        {locked, sym_err, meas_valid}, c);
      end
    end
    corrupt = 4'h0;
    repeat (150) strobe(4'h0);
    total++;
    if (locked !== 1'b1 || lock_loss_cnt !== 16'd1) begin
      bad++; $display("FAIL stall_resume: locked=%b loss=%0d want 1 and 1", locked, lock_loss_cnt);
    end
  endtask

  task automatic test_midlock_reset();
    @(negedge clk);
    reset = 1'b1; src_reset = 1'b1;
    #1;
    total++;
    if ({locked, sym_err, meas_valid} !== 3'b000) begin
      bad++; $display("FAIL midreset_flags: got %b want 000", {locked, sym_err, meas_valid});
    end
    total++;
    if ((bit_err_total | sym_err_total | sym_total) !== '0 || lock_loss_cnt !== 16'd0) begin
      bad++; $display("FAIL midreset_counters: got bit=%0d err=%0d sym=%0d loss=%0d want all 0",
                      bit_err_total, sym_err_total, sym_total, lock_loss_cnt);
    end
    @(negedge clk);
    reset = 1'b0; src_reset = 1'b0;
    model_clear();
    for (int k = 1; k <= 32; k++) begin
      strobe(4'h0);
      if (k == 31) begin
        total++;
        if (locked !== 1'b0) begin
          bad++; $display("FAIL midreset_early_lock: locked got %b want 0", locked);
        end
      end
    end
    total++;
    if (locked !== 1'b1) begin
      bad++; $display("FAIL midreset_relock: locked got %b want 1", locked);
    end
    model_lock_entry();
    repeat (140) strobe(4'h0);
  endtask

  initial begin
    test_reset();
    test_aligned();
    test_offset();
    test_single_fault();
    test_burst();
    test_stall();
    test_midlock_reset();
    @(negedge clk);
    total++;
    if (snap_q.size() != 0) begin
      bad++; $display("FAIL scoreboard_drained: %0d snapshots outstanding want 0", snap_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/lfsr_sym_checker.md
# lfsr_sym_checker

Receive-side pattern checker for the 4-bit LFSR symbol payload. It sits after the slicer/decision stage and takes decided 16-QAM symbols, one per symbol strobe. It aligns an internal replica of `lfsr_gen_max` to the incoming stream by symbol slipping, declares lock, and then counts symbol and bit errors. Totals are reported once per full LFSR period.

## Interface
Parameters:
- `LOCK_COUNT`, 32: consecutive matching symbols required to declare lock.
- `UNLOCK_WINDOW`, 64: symbol window length for loss-of-lock evaluation.
- `UNLOCK_THRESH`, 8: symbol errors within one window that force loss of lock.
- `CNT_W`, 32: width of the error and symbol counters.

Ports:
- `clk`, in, 1: system clock.
- `reset`, in, 1: asynchronous, active-high.
- `clk_en`, in, 1: symbol strobe; `sym_in` is valid on cycles where it is high.
- `sym_in`, in, 4: decided symbol.
- `locked`, out, 1: high in LOCKED state.
- `sym_err`, out, 1: registered one-cycle pulse on an erroneous symbol while locked.
- `meas_valid`, out, 1: one-cycle pulse; snapshot outputs were updated.
- `bit_err_total`, out, CNT_W: bit errors over the last completed period.
- `sym_err_total`, out, CNT_W: symbol errors over the last completed period.
- `sym_total`, out, CNT_W: symbols checked over the last completed period.
- `lock_loss_cnt`, out, 16: number of LOCKED→SEARCH transitions, saturating.

## Operation
- Reference path: one `lfsr_gen_max` instance.
  - Its `clk_en` is `clk_en & ~slip`.
  - Its `reset` is the block reset.
  - `ref_sym` is its `sym_out`.
- Compare: `mismatch = (sym_in != ref_sym)`. This is combinational and evaluated only when `clk_en` is high.
- `slip = clk_en & mismatch & (state != LOCKED)`. The reference is held for one symbol, which shifts the relative alignment by one.
- FSM states: SEARCH, VERIFY, LOCKED. Transitions occur only on `clk_en` cycles.
  - SEARCH, match: go to VERIFY with `match_cnt` = 1.
  - SEARCH, mismatch: stay in SEARCH and slip.
  - VERIFY, match: increment `match_cnt`. When `match_cnt` reaches `LOCK_COUNT`, go to LOCKED.
  - VERIFY, mismatch: go to SEARCH, clear `match_cnt`, and slip.
  - LOCKED: never slips.
    - Each symbol increments the live `sym` counter.
    - Each mismatch increments the live `sym_err` counter and adds popcount(`sym_in ^ ref_sym`) (0..4) to the live `bit_err` counter.
- Window logic, LOCKED only:
  - `win_cnt` counts symbols from 0 to `UNLOCK_WINDOW`-1.
  - `win_err` counts errors within the current window.
  - If `win_err` would reach `UNLOCK_THRESH`, go to SEARCH. This symbol does not slip. Increment `lock_loss_cnt`.
  - At window end, clear `win_cnt` and `win_err`.
- Snapshot: on the reference `cycle_out_periodic` pulse while LOCKED:
  - Copy the live counters to the `*_total` outputs and pulse `meas_valid`.
  - Clear the live counters. The symbol in the same cycle is counted into the new period.
- Live counters saturate at all-ones. They are never allowed to wrap.
- Entry to LOCKED clears the live counters and the window counters. Leaving LOCKED does not alter the `*_total` outputs.

## Timing
- Reset values:
  - State is SEARCH.
  - `locked`, `sym_err` and `meas_valid` are 0.
  - All totals, live counters, `match_cnt`, `win_*` and `lock_loss_cnt` are 0.
  - The reference LFSR is at `LFSR_SEED`.
- `locked` rises on the clock edge of the `LOCK_COUNT`-th consecutive match. It falls on the edge of the threshold error.
- `sym_err` is asserted the cycle after the erroneous strobe edge, for one cycle.
- `meas_valid` and the totals update on the edge following the periodic pulse. Latency is 1 cycle.
- Slip is zero-latency: the reference is held on the same edge as the mismatch.
- When `clk_en` is low, all state is frozen, the pulses are 0, and there is no slip.
- Simultaneous snapshot and threshold loss: snapshot is taken first, then the transition to SEARCH.
- Reset mid-operation: all state returns to reset values immediately (asynchronous). Reacquisition starts from SEARCH.

## Structure
- The shared `defines.vh` supplies `LFSR_LEN` and `LFSR_SEED`. Add `` `SYM_W `` = 4 there.
- The FSM state encodings go into the shared defines as `` `CHK_SEARCH ``, `` `CHK_VERIFY `` and `` `CHK_LOCKED ``.
- One sub-module: the existing `lfsr_gen_max` as reference generator.
- Popcount is a local function, not a separate module.

## Test plan
- Aligned input: a second `lfsr_gen_max` with the same seed and the same `clk_en` drives `sym_in` → `locked` = 1 after exactly 32 strobes; zero `sym_err`. The first `meas_valid` shows `sym_err_total` = 0 and `bit_err_total` = 0.
- Offset input: the source starts 5 symbols ahead → lock is achieved after the slips; `locked` holds; `lock_loss_cnt` = 0.
- Single fault: while locked, XOR `sym_in` with 4'b0101 once → one `sym_err` pulse; the next snapshot shows `sym_err_total` = 1 and `bit_err_total` = 2.
- Burst: 8 corrupted symbols within 64 strobes → `locked` falls on the 8th; `lock_loss_cnt` = 1; the block reacquires after the burst ends.
- Stall: `clk_en` held low for 100 cycles while locked → no state change and no pulses; lock persists.
- Reset asserted mid-lock for 1 cycle → all outputs are 0 immediately; the block relocks 32 strobes after the aligned source restarts.
